// File: rtl/spike_aer_encoder.sv
// Spike capture, round-robin AER serialiser and first-word-fall-through event FIFO.
// Each captured spike is timestamped with the free-running counter value of its capture cycle.
module spike_aer_encoder #(
  parameter int N_NEURONS  = 8,
  parameter int ADDR_W     = 3,
  parameter int TS_W       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_NEURONS-1:0]          spike_in,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [ADDR_W-1:0]             ev_addr,
  output logic [TS_W-1:0]               ev_ts,
  output logic [N_NEURONS-1:0]          pending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = ADDR_W + 1;

  logic [TS_W-1:0]      ts_r;
  logic [TS_W-1:0]      ts_lat_r [N_NEURONS];
  logic [N_NEURONS-1:0] pending_r;
  logic [ADDR_W-1:0]    rr_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [LVL_W-1:0]     level_r;
  logic [7:0]           drop_count_r;
  logic [ADDR_W-1:0]    fifo_addr_r [FIFO_DEPTH];
  logic [TS_W-1:0]      fifo_ts_r [FIFO_DEPTH];

  logic                 can_push_s;
  logic                 grant_s;
  logic [ADDR_W-1:0]    gnt_idx_s;
  logic [ADDR_W-1:0]    idx_s;
  logic [N_NEURONS-1:0] grant_vec_s;
  logic [N_NEURONS-1:0] keep_s;
  logic [N_NEURONS-1:0] capture_s;
  logic [N_NEURONS-1:0] drop_vec_s;
  logic [CNT_W-1:0]     drops_s;
  logic [15:0]          drop_sum_s;
  logic                 pop_s;

  assign ev_valid   = (level_r != {LVL_W{1'b0}});
  assign ev_addr    = fifo_addr_r[rd_ptr_r];
  assign ev_ts      = fifo_ts_r[rd_ptr_r];
  assign pending    = pending_r;
  assign fifo_level = level_r;
  assign drop_count = drop_count_r;
  assign pop_s      = ev_valid & ev_ready;
  // Slot availability is judged on the pre-pop level, so a pop never frees room in the same cycle.
  assign can_push_s = (level_r < LVL_W'(FIFO_DEPTH));

  // Round-robin search from rr_r upward, first pending neuron wins.
  always_comb begin
    grant_s   = 1'b0;
    gnt_idx_s = {ADDR_W{1'b0}};
    idx_s     = {ADDR_W{1'b0}};
    for (int off = 0; off < N_NEURONS; off++) begin
      idx_s = rr_r + ADDR_W'(off);
      if (!grant_s && can_push_s && pending_r[idx_s]) begin
        grant_s   = 1'b1;
        gnt_idx_s = idx_s;
      end else begin
        grant_s   = grant_s;
      end
    end
  end

  // Capture versus coalesce decision per neuron, after this cycle's grant clears its bit.
  always_comb begin
    grant_vec_s = {N_NEURONS{1'b0}};
    if (grant_s) begin
      grant_vec_s[gnt_idx_s] = 1'b1;
    end else begin
      grant_vec_s = {N_NEURONS{1'b0}};
    end
    keep_s     = pending_r & ~grant_vec_s;
    capture_s  = spike_in & ~keep_s;
    drop_vec_s = spike_in & keep_s;
    drops_s    = {CNT_W{1'b0}};
    for (int i = 0; i < N_NEURONS; i++) begin
      drops_s = drops_s + CNT_W'(drop_vec_s[i]);
    end
    drop_sum_s = 16'(drop_count_r) + 16'(drops_s);
  end

  // All state: timestamp, capture, arbiter pointer, FIFO storage and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_r         <= {TS_W{1'b0}};
      pending_r    <= {N_NEURONS{1'b0}};
      rr_r         <= {ADDR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= {LVL_W{1'b0}};
      drop_count_r <= 8'd0;
      for (int i = 0; i < N_NEURONS; i++) begin
        ts_lat_r[i] <= {TS_W{1'b0}};
      end
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_addr_r[j] <= {ADDR_W{1'b0}};
        fifo_ts_r[j]   <= {TS_W{1'b0}};
      end
    end else begin
      ts_r      <= ts_r + TS_W'(1);
      pending_r <= keep_s | spike_in;
      for (int i = 0; i < N_NEURONS; i++) begin
        if (capture_s[i]) begin
          ts_lat_r[i] <= ts_r;
        end else begin
          ts_lat_r[i] <= ts_lat_r[i];
        end
      end
      // The enqueued timestamp is the pre-edge latch, so a same-cycle recapture does not leak in.
      if (grant_s) begin
        fifo_addr_r[wr_ptr_r] <= gnt_idx_s;
        fifo_ts_r[wr_ptr_r]   <= ts_lat_r[gnt_idx_s];
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
        rr_r                  <= gnt_idx_s + ADDR_W'(1);
      end else begin
        rr_r <= rr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({grant_s, pop_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
      if (drop_sum_s > 16'd255) begin
        drop_count_r <= 8'hFF;
      end else begin
        drop_count_r <= drop_sum_s[7:0];
      end
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: expected events are queued at stimulus time
// and compared against every accepted output event.
module tb_spike_aer_encoder;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  spike_in = '0;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [AW-1:0] ev_addr;
  logic [TW-1:0] ev_ts;
  logic [N-1:0]  pending;
  logic [2:0]    fifo_level;
  logic [7:0]    drop_count;

  logic [TW-1:0]      tb_ts = '0;
  logic [AW+TW-1:0]   exp_q [$];
  int                 tests_run = 0;
  int                 tests_failed = 0;

  spike_aer_encoder #(.N_NEURONS(N), .ADDR_W(AW), .TS_W(TW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_ts(ev_ts), .pending(pending),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference timestamp: value of the DUT counter during the current cycle.
  always @(posedge clk) tb_ts <= rst_n ? tb_ts + 8'd1 : 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Accepted events are popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && ev_valid && ev_ready) begin
      check_eq("ev_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [AW+TW-1:0] e;
        e = exp_q.pop_front();
        check_eq("ev_addr", ev_addr, e[AW+TW-1:TW]);
        check_eq("ev_ts", ev_ts, e[TW-1:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic [TW-1:0] ts);
    logic [AW-1:0] a;
    a = AW'(addr);
    exp_q.push_back({a, ts});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    spike_in = '1;
    step();
    rst_n    = 1'b1;
    spike_in = '0;
    exp_q.delete();
  endtask

  task automatic wait_ts(input logic [TW-1:0] target);
    int n;
    n = 0;
    while (tb_ts != target && n < 300) begin
      step();
      n++;
    end
    if (tb_ts != target) check_eq("wait_ts", tb_ts, target);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic [TW-1:0] t0;

    // Reset state
    do_reset();
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_addr", ev_addr, 0);
    check_eq("rst_ts", ev_ts, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_pending", pending, 0);
    check_eq("rst_drop", drop_count, 0);

    // Single spike at ts=5, two-cycle latency, one-cycle valid pulse
    ev_ready = 1'b1;
    wait_ts(8'd5);
    push_exp(2, tb_ts);
    spike_in = 8'h04;
    step();
    spike_in = '0;
    check_eq("single_pending", pending, 8'h04);
    check_eq("single_valid_k1", ev_valid, 0);
    step();
    check_eq("single_valid_k2", ev_valid, 1);
    step();
    check_eq("single_valid_k3", ev_valid, 0);
    check_eq("single_drop", drop_count, 0);
    drain("single_drain");

    // Simultaneous spikes at ts=10
    do_reset();
    ev_ready = 1'b1;
    wait_ts(8'd10);
    for (int i = 0; i < N; i++) push_exp(i, tb_ts);
    spike_in = 8'hFF;
    step();
    spike_in = '0;
    repeat (12) step();
    check_eq("simul_valid", ev_valid, 0);
    check_eq("simul_pending", pending, 0);
    check_eq("simul_drain", exp_q.size(), 0);

    // Backpressure: FIFO fills, head stable, then gapless drain
    do_reset();
    ev_ready = 1'b0;
    step();
    t0 = tb_ts;
    for (int i = 0; i < N; i++) push_exp(i, t0);
    spike_in = 8'hFF;
    step();
    spike_in = '0;
    repeat (5) step();
    check_eq("bp_level", fifo_level, 4);
    check_eq("bp_pending", pending, 8'hF0);
    check_eq("bp_valid", ev_valid, 1);
    check_eq("bp_head_addr", ev_addr, 0);
    repeat (3) step();
    check_eq("bp_hold_addr", ev_addr, 0);
    check_eq("bp_hold_ts", ev_ts, t0);
    ev_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      check_eq("bp_no_gap", ev_valid, 1);
      step();
    end
    check_eq("bp_empty", ev_valid, 0);
    check_eq("bp_drain", exp_q.size(), 0);

    // Coalescing into a full FIFO with saturating drop counter
    do_reset();
    ev_ready = 1'b0;
    step();
    t0 = tb_ts;
    for (int i = 0; i < N; i++) push_exp(i, t0);
    spike_in = 8'hFF;
    step();
    spike_in = 8'h40;
    repeat (300) step();
    spike_in = '0;
    check_eq("coal_drop_sat", drop_count, 255);
    check_eq("coal_pending", pending, 8'hF0);
    ev_ready = 1'b1;
    drain("coal_drain");
    check_eq("coal_drop_hold", drop_count, 255);

    // Round-robin fairness under continuous spikes on neurons 0 and 1
    do_reset();
    ev_ready = 1'b1;
    step();
    t0 = tb_ts;
    push_exp(0, t0);
    for (int j = 1; j <= 8; j++) push_exp(j % 2, t0 + TW'(j - 1));
    spike_in = 8'h03;
    repeat (8) step();
    spike_in = '0;
    drain("rr_drain");
    check_eq("rr_drop", drop_count, 7);
    check_eq("rr_pending", pending, 0);

    // Timestamp wrap 255 -> 0
    do_reset();
    ev_ready = 1'b1;
    wait_ts(8'd255);
    push_exp(0, 8'd255);
    push_exp(1, 8'd0);
    spike_in = 8'h01;
    step();
    spike_in = 8'h02;
    step();
    spike_in = '0;
    drain("wrap_drain");

    // Reset mid-stream with three buffered events
    do_reset();
    ev_ready = 1'b0;
    spike_in = 8'h07;
    step();
    spike_in = 8'h04;
    step();
    spike_in = '0;
    repeat (4) step();
    check_eq("mid_level", fifo_level, 3);
    check_eq("mid_drop", drop_count, 1);
    do_reset();
    check_eq("mid_rst_valid", ev_valid, 0);
    check_eq("mid_rst_level", fifo_level, 0);
    check_eq("mid_rst_pending", pending, 0);
    check_eq("mid_rst_drop", drop_count, 0);
    ev_ready = 1'b1;
    repeat (4) step();
    check_eq("mid_after_valid", ev_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream collector for a bank of LIF neurons. It captures single-cycle spike pulses from `N_NEURONS` neurons and timestamps each spike at capture. A round-robin arbiter serialises the captured spikes into address-event (AER) words. Events are buffered in a small FIFO and presented on a valid/ready stream to the readout or next layer.

## Interface
Parameters:
- `N_NEURONS`, default 8: number of spike inputs. Must be a power of two, ≥2.
- `ADDR_W`, default 3: event address width, equal to log2(`N_NEURONS`).
- `TS_W`, default 8: timestamp width.
- `FIFO_DEPTH`, default 4: event FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `spike_in`  in  N_NEURONS: spike pulses, one bit per neuron, sampled every edge.
- `ev_valid`  out  1: FIFO head holds an event.
- `ev_ready`  in  1: consumer accepts the head event.
- `ev_addr`  out  ADDR_W: neuron index of the head event.
- `ev_ts`  out  TS_W: timestamp of the head event.
- `pending`  out  N_NEURONS: captured, not yet enqueued spikes.
- `fifo_level`  out  log2(FIFO_DEPTH)+1: current FIFO occupancy.
- `drop_count`  out  8: coalesced-spike counter, saturating.

## Operation
- **Timestamp counter `ts`:** increments every cycle and wraps from 2^TS_W−1 to 0.
- **Capture:**
  - When `spike_in[i]`=1 and `pending[i]`=0 (after this cycle's grant clear), set `pending[i]` and latch `ts_lat[i]` ← current `ts`.
  - When `spike_in[i]`=1 while `pending[i]` stays set, the spike is coalesced: `ts_lat[i]` keeps its original value and `drop_count` increments, saturating at 255.
  - When `spike_in[i]`=1 in the same cycle `i` is granted, the old event is enqueued. `pending[i]` stays set with `ts_lat[i]` ← current `ts`. This is not a drop.
  - Multiple coalesced spikes in one cycle add their count to `drop_count`, saturating.
- **Arbiter:**
  - Round-robin pointer `rr`, reset to 0.
  - Searches `pending` from index `rr` upward, wrapping to 0.
  - Grants the first set bit, at most one grant per cycle.
  - Grants only when `fifo_level` < `FIFO_DEPTH`, evaluated before this cycle's pop. A pop does not free a slot for the same cycle.
  - On a grant of `i`: write {`i`, `ts_lat[i]`} into the FIFO, clear `pending[i]` (unless recaptured, as above), and set `rr` ← (i+1) mod N_NEURONS.
  - With no grant, `rr` holds.
- **FIFO:**
  - First-word-fall-through. `ev_valid` = (level ≠ 0). `ev_addr`/`ev_ts` show the head entry.
  - A pop occurs when `ev_valid` and `ev_ready` are both 1.
  - Simultaneous push and pop leaves the level unchanged.
  - `ev_addr`/`ev_ts` stay stable while `ev_valid`=1 and `ev_ready`=0.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Full FIFO:** spikes keep being captured into `pending` and coalesced. No event is lost except by coalescing.

## Timing
- **Reset values:** `ts`, `pending`, `ts_lat`, `rr`, FIFO pointers, `fifo_level`, `drop_count` are all 0. Consequently `ev_valid`=0, `ev_addr`=0, `ev_ts`=0.
- **Reset priority:** reset overrides all activity, including mid-stream with the FIFO partly full. Buffered and pending events are discarded. `spike_in` during the reset cycle is ignored.
- **Latency:**
  - `spike_in[i]` high in cycle k → `pending[i]`=1 in cycle k+1.
  - If granted in cycle k+1, `ev_valid`=1 in cycle k+2 (2 cycles, uncontended).
  - `ev_ts` equals `ts` in cycle k.
- **Throughput:** at most one event enqueued and one dequeued per cycle.
- **Outputs:** `pending`, `fifo_level`, `drop_count` are registered and reflect state after the last edge.

## Test plan
- **Single spike:** reset, then `spike_in`=0x04 for one cycle at `ts`=5, `ev_ready`=1 → `ev_valid` high exactly 1 cycle, two cycles later, with `ev_addr`=2, `ev_ts`=5. `drop_count`=0.
- **Simultaneous spikes:** `spike_in`=0xFF one cycle at `ts`=10, `ev_ready`=1 → 8 consecutive events with addr 0,1,…,7, all `ev_ts`=10. Then `ev_valid`=0 and `pending`=0.
- **Backpressure:** `ev_ready`=0, `spike_in`=0xFF one cycle → `fifo_level` reaches 4 (addr 0–3), `pending`=0xF0, head stable. Raise `ev_ready` → remaining order 0,1,2,3,4,5,6,7 with no gaps after the first pop.
- **Coalescing and saturation:** with the FIFO full, pulse neuron 6 (already pending) 300 times → `drop_count` stops at 255. The event for neuron 6 later emerges with its original timestamp.
- **Round-robin fairness:** hold `spike_in`=0x03 continuously, `ev_ready`=1 → addresses alternate 0,1,0,1. Neither neuron starves.
- **Timestamp wrap and reset:**
  - A spike at `ts`=255 followed by a spike at `ts`=0 → events carry 255 then 0.
  - Assert `rst_n`=0 for one cycle with 3 events buffered → next cycle `ev_valid`=0, `fifo_level`=0, `pending`=0, `drop_count`=0.
